// File: rtl/clk_monitor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_monitor_pkg                                                 |
// | Purpose  : Shared types and default parameter values for the clock monitor |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package clk_monitor_pkg;

  // Monitor operating states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2,
    LOST    = 2'd3
  } state_e;

  // Sticky error flags used by the optional interrupt logic
  typedef struct packed {
    logic lost;
    logic slow;
    logic fast;
  } sticky_t;

  // Default configuration: roughly an 8-cycle monitored period with +/-1 slack
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_EXP_MIN  = 7;
  localparam int DEF_EXP_MAX  = 9;
  localparam int DEF_TIMEOUT  = 32;
  localparam int DEF_LOCK_CNT = 4;

endpackage : clk_monitor_pkg
`default_nettype wire

// File: rtl/clk_monitor_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_monitor_sync                                                |
// | Purpose  : Two-flop synchronizer plus history flop; emits a one-cycle      |
// |            pulse on each synchronized rising edge of an async input.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module clk_monitor_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic sync1;  // metastability capture stage
  logic sync2;  // first stable sample
  logic sync3;  // previous stable sample, for edge detection

  // Shift the asynchronous input through the synchronizer and history stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // A rising edge is a stable high that was low one cycle earlier
  assign rise = sync2 & ~sync3;

endmodule : clk_monitor_sync
`default_nettype wire

// File: rtl/clk_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_monitor                                                     |
// | Purpose  : Measures the period of a foreign free-running clock in system   |
// |            clock cycles, checks it against a window and reports lock,      |
// |            too-fast, too-slow and loss-of-clock status.                    |
// | Options  : CLK_MONITOR_IRQ_EN - builds sticky error bits and a registered  |
// |            interrupt cleared by err_clr; otherwise irq is tied low.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int EXP_MIN  = DEF_EXP_MIN,
  parameter int EXP_MAX  = DEF_EXP_MAX,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] period_out,
  output logic             period_vld,
  output logic             locked,
  output logic             too_fast,
  output logic             too_slow,
  output logic             lost,
  input  logic             err_clr,
  output logic             irq
);

  // Width of the consecutive-good-period counter (must hold LOCK_CNT)
  localparam int GOOD_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  EXP_MIN_C  = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0]  EXP_MAX_C  = CNT_W'(EXP_MAX);
  localparam logic [CNT_W-1:0]  TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [GOOD_W-1:0] LOCK_C     = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] LOCK_PRE_C = GOOD_W'(LOCK_CNT - 1);

  // Reject configurations where the window, timeout or counter width disagree
  generate
    if (!((EXP_MIN <= EXP_MAX) && (EXP_MAX < TIMEOUT) &&
          (64'(TIMEOUT) < (64'd1 << CNT_W)) && (LOCK_CNT >= 1))) begin : g_param_check
      $error("clk_monitor: need EXP_MIN <= EXP_MAX < TIMEOUT < 2**CNT_W and LOCK_CNT >= 1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Edge detection of the monitored clock
  // --------------------------------------------------------------------------
  logic rise;

  clk_monitor_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (mon_clk),
    .rise     (rise)
  );

  // --------------------------------------------------------------------------
  // State and next-state signals
  // --------------------------------------------------------------------------
  state_e            state;
  state_e            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_nxt;
  logic [CNT_W-1:0]  period_nxt;
  logic              period_vld_nxt;
  logic              locked_nxt;
  logic              too_fast_nxt;
  logic              too_slow_nxt;
  logic              lost_nxt;
  logic              timeout;
  logic              in_window;
  logic              below_min;

  // Saturating increment so a dead clock never wraps back into the window
  assign cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_ONE;
  assign timeout   = (cnt == TIMEOUT_C);
  assign below_min = (cnt < EXP_MIN_C);
  assign in_window = !below_min && (cnt <= EXP_MAX_C);

  // Next-state, period counter, lock tracking and status pulse decode
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt_inc;
    good_nxt       = good_cnt;
    period_nxt     = period_out;
    period_vld_nxt = 1'b0;
    locked_nxt     = locked;
    too_fast_nxt   = 1'b0;
    too_slow_nxt   = 1'b0;
    lost_nxt       = lost;

    if (!enable) begin
      // Disable overrides everything, including a coincident edge
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      good_nxt   = '0;
      locked_nxt = 1'b0;
      lost_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ACQUIRE;
          cnt_nxt   = '0;
        end

        ACQUIRE: begin
          // The first edge only opens a measurement; nothing to report yet
          if (rise) begin
            state_nxt = MEASURE;
            cnt_nxt   = CNT_ONE;
          end else if (timeout) begin
            state_nxt = LOST;
            lost_nxt  = 1'b1;
          end
        end

        MEASURE: begin
          // An edge on the timeout cycle still counts as a valid period
          if (rise) begin
            cnt_nxt        = CNT_ONE;
            period_nxt     = cnt;
            period_vld_nxt = 1'b1;
            if (in_window) begin
              if (good_cnt != LOCK_C) begin
                good_nxt = good_cnt + 1'b1;
              end
              if (good_cnt >= LOCK_PRE_C) begin
                locked_nxt = 1'b1;
              end
            end else begin
              good_nxt     = '0;
              locked_nxt   = 1'b0;
              too_fast_nxt = below_min;
              too_slow_nxt = !below_min;
            end
          end else if (timeout) begin
            state_nxt  = LOST;
            lost_nxt   = 1'b1;
            locked_nxt = 1'b0;
            good_nxt   = '0;
          end
        end

        LOST: begin
          // Recovery edge restarts measurement but has no valid predecessor
          if (rise) begin
            state_nxt = MEASURE;
            cnt_nxt   = CNT_ONE;
            lost_nxt  = 1'b0;
          end
        end

        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Period counter, lock counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      good_cnt   <= '0;
      period_out <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      too_fast   <= 1'b0;
      too_slow   <= 1'b0;
      lost       <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      good_cnt   <= good_nxt;
      period_out <= period_nxt;
      period_vld <= period_vld_nxt;
      locked     <= locked_nxt;
      too_fast   <= too_fast_nxt;
      too_slow   <= too_slow_nxt;
      lost       <= lost_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Optional sticky error interrupt
  // --------------------------------------------------------------------------
`ifdef CLK_MONITOR_IRQ_EN
  sticky_t sticky;
  sticky_t sticky_nxt;
  logic    lost_q;

  // Clear first, then OR in new events so a coincident event survives the clear
  always_comb begin
    sticky_nxt      = err_clr ? '0 : sticky;
    sticky_nxt.fast = sticky_nxt.fast | too_fast;
    sticky_nxt.slow = sticky_nxt.slow | too_slow;
    sticky_nxt.lost = sticky_nxt.lost | (lost & ~lost_q);
  end

  // Sticky bits, loss-edge history and registered interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= '0;
      lost_q <= 1'b0;
      irq    <= 1'b0;
    end else begin
      sticky <= sticky_nxt;
      lost_q <= lost;
      irq    <= |sticky_nxt;
    end
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign irq            = 1'b0;
`endif

endmodule : clk_monitor
`default_nettype wire

// File: tb/tb_clk_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_clk_monitor                                                  |
// | Purpose  : Self-checking bench for clk_monitor with a period scoreboard    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_clk_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        mon_clk = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] period_out;
  logic        period_vld;
  logic        locked;
  logic        too_fast;
  logic        too_slow;
  logic        lost;
  logic        irq;

  clk_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mon_clk    (mon_clk),
    .period_out (period_out),
    .period_vld (period_vld),
    .locked     (locked),
    .too_fast   (too_fast),
    .too_slow   (too_slow),
    .lost       (lost),
    .err_clr    (err_clr),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int period;
    bit fast;
    bit slow;
    bit lk;
  } exp_t;

  exp_t exp_q[$];

  // Monitored-clock generator controls
  bit mon_run    = 1'b0;
  bit first_edge = 1'b1;
  int cur_hi     = 4;
  int cur_lo     = 4;
  int hi_l       = 4;
  int lo_l       = 4;
  int ph         = 0;
  int last_rise  = 0;
  int model_good = 0;

  // Drives mon_clk in whole clk cycles and pushes the expected report per edge
  initial begin : gen
    int   p;
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!mon_run) begin
        mon_clk = 1'b0;
        ph      = 0;
      end else begin
        if (ph == 0) begin
          hi_l    = cur_hi;
          lo_l    = cur_lo;
          mon_clk = 1'b1;
          if (first_edge) begin
            first_edge = 1'b0;
            model_good = 0;
          end else begin
            p        = cyc - last_rise;
            e.period = p;
            e.fast   = (p < 7);
            e.slow   = (p > 9);
            if (e.fast || e.slow) model_good = 0;
            else if (model_good < 4) model_good++;
            e.lk = (model_good == 4);
            exp_q.push_back(e);
          end
          last_rise = cyc;
        end else if (ph == hi_l) begin
          mon_clk = 1'b0;
        end
        ph++;
        if (ph == hi_l + lo_l) ph = 0;
      end
    end
  end

  // Restart the monitor from IDLE with a quiet input, then run at hi/lo
  task automatic start_mon(input int hi, input int lo);
    @(negedge clk);
    mon_run = 1'b0;
    enable  = 1'b0;
    repeat (5) @(negedge clk);
    exp_q.delete();
    first_edge = 1'b1;
    cur_hi     = hi;
    cur_lo     = lo;
    enable     = 1'b1;
    mon_run    = 1'b1;
  endtask

  task automatic test_reset();
    int bad = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({period_out, period_vld, locked, too_fast, too_slow, lost, irq} !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs got %h expected 0",
               {period_out, period_vld, locked, too_fast, too_slow, lost, irq});
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if ({period_out, period_vld, locked, too_fast, too_slow, lost, irq} !== 22'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL idle_outputs got %0d nonzero cycles expected 0", bad);
    end
  endtask

  task automatic test_lock();
    exp_t e;
    int   nvld = 0;
    start_mon(4, 4);
    repeat (70) begin
      @(negedge clk);
      if (period_vld) begin
        nvld++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL lock_extra_vld got period_out=%0d expected no pulse", period_out);
        end else begin
          e = exp_q.pop_front();
          if ({period_out, too_fast, too_slow, locked, lost} !== {16'(e.period), e.fast, e.slow, e.lk, 1'b0}) begin
            failures++;
            $display("FAIL lock_period got p=%0d f=%0b s=%0b l=%0b lost=%0b expected p=%0d f=%0b s=%0b l=%0b lost=0",
                     period_out, too_fast, too_slow, locked, lost, e.period, e.fast, e.slow, e.lk);
          end
        end
      end else if (too_fast || too_slow) begin
        checks++;
        failures++;
        $display("FAIL lock_stray_pulse got f=%0b s=%0b expected 0", too_fast, too_slow);
      end
    end
    checks++;
    if (nvld < 6) begin
      failures++;
      $display("FAIL lock_vld_count got %0d expected >=6", nvld);
    end
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL lock_final got locked=%0b expected 1", locked);
    end
  endtask

  task automatic test_too_fast();
    exp_t e;
    int   nfast = 0;
    for (int ph_i = 0; ph_i < 2; ph_i++) begin
      cur_hi = (ph_i == 0) ? 2 : 4;
      cur_lo = cur_hi;
      repeat (ph_i == 0 ? 40 : 60) begin
        @(negedge clk);
        if (period_vld) begin
          checks++;
          if (too_fast) nfast++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL fast_extra_vld got period_out=%0d expected no pulse", period_out);
          end else begin
            e = exp_q.pop_front();
            if ({period_out, too_fast, too_slow, locked, lost} !== {16'(e.period), e.fast, e.slow, e.lk, 1'b0}) begin
              failures++;
              $display("FAIL fast_period got p=%0d f=%0b s=%0b l=%0b lost=%0b expected p=%0d f=%0b s=%0b l=%0b lost=0",
                       period_out, too_fast, too_slow, locked, lost, e.period, e.fast, e.slow, e.lk);
            end
          end
        end else if (too_fast || too_slow) begin
          checks++;
          failures++;
          $display("FAIL fast_stray_pulse got f=%0b s=%0b expected 0", too_fast, too_slow);
        end
      end
    end
    checks++;
    if (nfast < 3) begin
      failures++;
      $display("FAIL fast_count got %0d expected >=3", nfast);
    end
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL fast_relock got locked=%0b expected 1", locked);
    end
  endtask

  task automatic test_too_slow();
    exp_t e;
    int   nslow = 0;
    cur_hi = 6;
    cur_lo = 6;
    repeat (80) begin
      @(negedge clk);
      if (period_vld) begin
        checks++;
        if (too_slow) nslow++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL slow_extra_vld got period_out=%0d expected no pulse", period_out);
        end else begin
          e = exp_q.pop_front();
          if ({period_out, too_fast, too_slow, locked, lost} !== {16'(e.period), e.fast, e.slow, e.lk, 1'b0}) begin
            failures++;
            $display("FAIL slow_period got p=%0d f=%0b s=%0b l=%0b lost=%0b expected p=%0d f=%0b s=%0b l=%0b lost=0",
                     period_out, too_fast, too_slow, locked, lost, e.period, e.fast, e.slow, e.lk);
          end
        end
      end
    end
    checks++;
    if (nslow < 4) begin
      failures++;
      $display("FAIL slow_count got %0d expected >=4", nslow);
    end
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL slow_locked got locked=%0b expected 0", locked);
    end
  endtask

  // Window edges 7/9 (in), 6/10 (out) and a 32-cycle period that meets the timeout
  task automatic test_boundary();
    exp_t e;
    int   his [5] = '{3, 4, 3, 5, 16};
    int   los [5] = '{4, 5, 3, 5, 16};
    int   lens[5] = '{40, 40, 30, 40, 120};
    bit   saw_lost = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cur_hi = his[k];
      cur_lo = los[k];
      repeat (lens[k]) begin
        @(negedge clk);
        if (lost) saw_lost = 1'b1;
        if (period_vld) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL bound_extra_vld got period_out=%0d expected no pulse", period_out);
          end else begin
            e = exp_q.pop_front();
            if ({period_out, too_fast, too_slow, locked, lost} !== {16'(e.period), e.fast, e.slow, e.lk, 1'b0}) begin
              failures++;
              $display("FAIL bound_period got p=%0d f=%0b s=%0b l=%0b lost=%0b expected p=%0d f=%0b s=%0b l=%0b lost=0",
                       period_out, too_fast, too_slow, locked, lost, e.period, e.fast, e.slow, e.lk);
            end
          end
        end
      end
    end
    checks++;
    if (saw_lost !== 1'b0) begin
      failures++;
      $display("FAIL bound_timeout_tie got lost=1 expected 0");
    end
  endtask

  task automatic test_loss();
    exp_t e;
    int   last_vld = -1000;
    int   lost_at  = -1;
    bit   got_lk   = 1'b0;
    bit   bad_vld  = 1'b0;
    int   clr_wait = -1;
    start_mon(4, 4);
    for (int i = 0; i < 100 && !got_lk; i++) begin
      @(negedge clk);
      if (period_vld) begin
        last_vld = cyc;
        if (exp_q.size() > 0) e = exp_q.pop_front();
      end
      got_lk = locked;
    end
    checks++;
    if (got_lk !== 1'b1) begin
      failures++;
      $display("FAIL loss_prelock got locked=0 expected 1");
    end
    mon_run = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (period_vld) begin
        last_vld = cyc;
        if (exp_q.size() > 0) e = exp_q.pop_front();
      end
      if (lost) begin
        lost_at = cyc;
        break;
      end
    end
    checks++;
    if (lost_at - last_vld !== 32) begin
      failures++;
      $display("FAIL loss_latency got %0d cycles (lost_at=%0d) expected 32", lost_at - last_vld, lost_at);
    end
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL loss_locked got locked=%0b expected 0", locked);
    end
    // Restart: the first edge only clears loss
    first_edge = 1'b1;
    cur_hi     = 4;
    cur_lo     = 4;
    mon_run    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (period_vld) bad_vld = 1'b1;
      if (!lost) begin
        clr_wait = i;
        break;
      end
    end
    checks++;
    if (clr_wait < 0 || bad_vld) begin
      failures++;
      $display("FAIL loss_clear got lost=%0b vld_seen=%0b expected lost=0 without vld", lost, bad_vld);
    end
    repeat (60) begin
      @(negedge clk);
      if (period_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL loss_extra_vld got period_out=%0d expected no pulse", period_out);
        end else begin
          e = exp_q.pop_front();
          if ({period_out, too_fast, too_slow, locked, lost} !== {16'(e.period), e.fast, e.slow, e.lk, 1'b0}) begin
            failures++;
            $display("FAIL loss_period got p=%0d f=%0b s=%0b l=%0b lost=%0b expected p=%0d f=%0b s=%0b l=%0b lost=0",
                     period_out, too_fast, too_slow, locked, lost, e.period, e.fast, e.slow, e.lk);
          end
        end
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL loss_relock got locked=%0b expected 1", locked);
    end
  endtask

  task automatic test_disable();
    int nact = 0;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL disable_locked got locked=%0b expected 0", locked);
    end
    repeat (40) begin
      @(negedge clk);
      if (period_vld || too_fast || too_slow || lost || locked) nact++;
    end
    checks++;
    if (nact !== 0) begin
      failures++;
      $display("FAIL disable_quiet got %0d active cycles expected 0", nact);
    end
    checks++;
    if (period_out !== 16'd8) begin
      failures++;
      $display("FAIL disable_hold got period_out=%0d expected 8", period_out);
    end
  endtask

  task automatic test_reset_mid();
    int nvld = 0;
    start_mon(4, 4);
    repeat (50) @(negedge clk);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_prelock got locked=%0b expected 1", locked);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({period_out, period_vld, locked, too_fast, too_slow, lost, irq} !== 22'd0) begin
      failures++;
      $display("FAIL rstmid_async got %h expected 0",
               {period_out, period_vld, locked, too_fast, too_slow, lost, irq});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({period_out, period_vld, locked, too_fast, too_slow, lost, irq} !== 22'd0) begin
      failures++;
      $display("FAIL rstmid_hold got %h expected 0",
               {period_out, period_vld, locked, too_fast, too_slow, lost, irq});
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (period_vld || too_fast || too_slow) nvld++;
    end
    checks++;
    if (nvld !== 0) begin
      failures++;
      $display("FAIL rstmid_nopulse got %0d pulse cycles expected 0", nvld);
    end
    mon_run = 1'b0;
  endtask

`ifdef CLK_MONITOR_IRQ_EN
  task automatic test_irq();
    bit found = 1'b0;
    start_mon(6, 6);
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = too_slow;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL irq_no_slow got too_slow=0 expected a pulse");
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_set got irq=%0b expected 1", irq);
    end
    cur_hi = 4;
    cur_lo = 4;
    repeat (30) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_hold got irq=%0b expected 1", irq);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear got irq=%0b expected 0", irq);
    end
    // Hold the clear while a too_fast arrives: the event must win
    err_clr = 1'b1;
    cur_hi  = 2;
    cur_lo  = 2;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = too_fast;
    end
    @(negedge clk);
    checks++;
    if (!found || irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_clr_vs_set got irq=%0b fast_seen=%0b expected 1", irq, found);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_clr_after got irq=%0b expected 0", irq);
    end
    err_clr = 1'b0;
  endtask
`else
  task automatic test_irq();
    bit saw_irq  = 1'b0;
    bit saw_fast = 1'b0;
    start_mon(2, 2);
    repeat (50) begin
      @(negedge clk);
      err_clr = ~err_clr;
      if (irq !== 1'b0) saw_irq = 1'b1;
      if (too_fast) saw_fast = 1'b1;
    end
    err_clr = 1'b0;
    checks++;
    if (saw_irq || !saw_fast) begin
      failures++;
      $display("FAIL irq_tied got irq_seen=%0b fast_seen=%0b expected irq 0 with fast 1", saw_irq, saw_fast);
    end
  endtask
`endif

  initial begin : main
    test_reset();
    test_lock();
    test_too_fast();
    test_too_slow();
    test_boundary();
    test_loss();
    test_disable();
    test_reset_mid();
    test_irq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout expected bench completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule : tb_clk_monitor
`default_nettype wire
